// File: rtl/array_pkg.sv
// Shared definitions for the row-array reader and writer blocks.
//
// Contents:
//   DW, DEPTH, AW : default data width, row count and row address width.
//   state_t       : reader sequencing states.
//   tri_mask      : triangular column mask used by both sides of the array.
//
// Data words use MSB-first indexing, so they are declared [0:DW-1]. Bit 0 is
// the leftmost (most significant) bit.
package array_pkg;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Keeps columns 1..row. Column 0 is never kept. Rows at or above DW-1 keep
  // every column except 0.
  function automatic logic [0:DW-1] tri_mask(input logic [AW-1:0] row);
    logic [0:DW-1] m;
    m = '0;
    for (int j = 1; j < DW; j++) begin
      if (j <= int'(row)) m[j] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that holds {index, data} pairs between the array read port
// and the output handshake.
//
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset.
//   push           : write push_index/push_data this cycle.
//   push_index     : row number of the pushed word.
//   push_data      : pushed word.
//   pop            : the head entry is consumed this cycle.
//   count          : current occupancy, 0..2.
//   head_index     : row number of the head entry.
//   head_data      : head entry word.
//
// The producer guarantees that it never pushes into a full FIFO unless it also
// pops that cycle. Both strobes are still guarded here, so a stray strobe
// cannot corrupt the occupancy.
module skid_fifo2 #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_index,
  input  logic [0:DW-1] push_data,
  input  logic          pop,
  output logic [1:0]    count,
  output logic [AW-1:0] head_index,
  output logic [0:DW-1] head_data
);

  logic [AW-1:0] idx_mem [2];
  logic [0:DW-1] dat_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        idx_mem[i] <= '0;
        dat_mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        idx_mem[wr_ptr] <= push_index;
        dat_mem[wr_ptr] <= push_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign count      = cnt;
  assign head_index = idx_mem[rd_ptr];
  assign head_data  = dat_mem[rd_ptr];

endmodule

// File: rtl/aa_array_reader.sv
// Read-side sequencer for the row array. A start pulse walks rows
// first_row..last_row, reads each row through the one-cycle-latency array
// port, optionally applies the triangular column mask, and streams the rows
// out on a valid/ready interface through a two-entry buffer.
//
// Ports:
//   clk, rst_n          : clock and asynchronous active-low reset.
//   start               : run request; ignored unless idle.
//   first_row, last_row : inclusive row range, sampled with start.
//   tri_mode            : apply the triangular mask, sampled with start.
//   busy                : run in progress.
//   done                : one-cycle pulse at the end of a run.
//   rd_en, rd_addr      : array read strobe and row.
//   rd_data             : array data, valid the cycle after rd_en.
//   out_valid/out_ready : output handshake.
//   out_data, out_index : head word and its row number.
//
// state  | meaning
// IDLE   | waiting for start
// READ   | issuing array reads while the buffer has room
// DRAIN  | all reads issued; waiting for the last words to leave
// FINISH | done pulse, back to IDLE next cycle
module aa_array_reader #(
  parameter int DW    = array_pkg::DW,
  parameter int DEPTH = array_pkg::DEPTH,
  parameter int AW    = array_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] first_row,
  input  logic [AW-1:0] last_row,
  input  logic          tri_mode,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [0:DW-1] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:DW-1] out_data,
  output logic [AW-1:0] out_index
);

  import array_pkg::*;

  if ((2 ** AW) != DEPTH) begin : g_bad_depth
    $error("aa_array_reader: 2**AW must equal DEPTH");
  end

  state_t        state_q;
  state_t        state_d;

  // One bit wider than a row address so that stepping past row 15 cannot
  // wrap back onto row 0.
  logic [AW:0]   row_q;
  logic [AW-1:0] last_q;
  logic          tri_q;
  logic          inflight_q;
  logic [AW-1:0] idx_q;

  logic [1:0]    fifo_count;
  logic          pop;
  logic [2:0]    occ;
  logic [0:DW-1] push_data;

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign rd_addr   = row_q[AW-1:0];

  // Buffer slots that will be taken at the end of this cycle if nothing new
  // is issued: current words, minus the one leaving now, plus the read whose
  // data arrives now. Issuing only while this is below 2 means a read always
  // has a slot when its data comes back.
  assign occ = {1'b0, fifo_count} - {2'b0, pop} + {2'b0, inflight_q};

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    busy    = (state_q != IDLE);
    done    = (state_q == FINISH);
    unique case (state_q)
      IDLE: begin
        // An empty range still passes through DRAIN, which finds nothing
        // outstanding, so done always follows start by at least two cycles.
        if (start) state_d = (first_row <= last_row) ? READ : DRAIN;
      end
      READ: begin
        rd_en = (occ < 3'd2);
        if (rd_en && (row_q == {1'b0, last_q})) state_d = DRAIN;
      end
      DRAIN: begin
        // The buffer counts as empty if its last word leaves this cycle.
        if (!inflight_q &&
            ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      last_q     <= '0;
      tri_q      <= 1'b0;
      inflight_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      idx_q      <= rd_addr;
      if ((state_q == IDLE) && start) begin
        row_q  <= {1'b0, first_row};
        last_q <= last_row;
        tri_q  <= tri_mode;
      end else if (rd_en) begin
        row_q  <= row_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  assign push_data = tri_q ? (rd_data & tri_mask(idx_q)) : rd_data;

  skid_fifo2 #(
    .DW (DW),
    .AW (AW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_q),
    .push_index (idx_q),
    .push_data  (push_data),
    .pop        (pop),
    .count      (fifo_count),
    .head_index (out_index),
    .head_data  (out_data)
  );

endmodule

// File: tb/tb_aa_array_reader.sv
module tb_aa_array_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] first_row;
  logic [3:0] last_row;
  logic       tri_mode;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [0:7] rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [0:7] out_data;
  logic [3:0] out_index;

  aa_array_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first_row (first_row),
    .last_row  (last_row),
    .tri_mode  (tri_mode),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int first;
    int last;
    int tmode;
    int pat;      // 0: all FF, 1: r*17, 2: random
    int mode;     // ready: 0 always, 1 toggle, 2 toggle with stall
    int rep_k;    // cycle of a second start pulse, 0 = none
    int exp_done; // -1 = not checked
    int exp_n;
  } vec_t;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] data;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   edges = 0;
  int   base  = 0;
  int   ready_mode = 0;

  logic [7:0] mem [16];
  exp_t       exp_q [$];
  vec_t       tbl [$];

  bit   mon_on = 0;
  int   done_cnt, done_k, valid_cnt, first_valid_k, rd_cnt, words_got, outstanding;
  bit   stall_prev;
  logic [7:0] prev_data;
  logic [3:0] prev_index;

  always @(posedge clk) edges <= edges + 1;

  // Array storage model: one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event want none", nm);
  endtask

  // Expected output word: keep columns 1..min(row,7), counted from the MSB.
  function automatic logic [7:0] model_word(input logic [7:0] raw, input int r, input int tmode);
    int k;
    if (tmode == 0) return raw;
    k = (r > 7) ? 7 : r;
    return raw & (8'h7F & ~(8'hFF >> (k + 1)));
  endfunction

  // Ready driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      int k;
      @(posedge clk);
      #1;
      k = edges - base;
      case (ready_mode)
        1: out_ready = (k % 2 == 1);
        2: out_ready = (k >= 6 && k <= 10) ? 1'b0 : (k % 2 == 1);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    if (mon_on) begin
      bit   pop_now;
      exp_t e;
      pop_now = out_valid && out_ready;
      if (done) begin
        done_cnt++;
        done_k = edges - base;
      end
      if (out_valid) begin
        valid_cnt++;
        if (first_valid_k < 0) first_valid_k = edges - base;
      end
      if (rd_en) begin
        rd_cnt++;
        chk("issue_room", int'((outstanding - int'(pop_now)) < 2), 1);
      end
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_index", out_index, prev_index);
      end
      if (pop_now) begin
        if (exp_q.size() == 0) fail_now("extra_word");
        else begin
          e = exp_q.pop_front();
          chk("word_data", out_data, e.data);
          chk("word_index", out_index, e.idx);
          words_got++;
        end
      end
      outstanding = outstanding + int'(rd_en) - int'(pop_now);
      stall_prev  = out_valid && !out_ready;
      prev_data   = out_data;
      prev_index  = out_index;
    end
  end

  task automatic run(input vec_t v);
    int n;
    for (int r = 0; r < 16; r++) begin
      case (v.pat)
        0: mem[r] = 8'hFF;
        1: mem[r] = 8'(r * 17);
        default: mem[r] = 8'($urandom_range(0, 255));
      endcase
    end
    exp_q.delete();
    if (v.first <= v.last)
      for (int r = v.first; r <= v.last; r++)
        exp_q.push_back('{idx: 4'(r), data: model_word(mem[r], r, v.tmode)});
    n = exp_q.size();
    done_cnt = 0; done_k = -1; valid_cnt = 0; first_valid_k = -1;
    rd_cnt = 0; words_got = 0; outstanding = 0; stall_prev = 0;
    ready_mode = v.mode;
    mon_on = 1;
    @(posedge clk);
    #1;
    base = edges;
    start = 1'b1;
    first_row = 4'(v.first);
    last_row = 4'(v.last);
    tri_mode = v.tmode[0];
    @(posedge clk);
    #1;
    start = 1'b0;
    first_row = 4'($urandom_range(0, 15));
    last_row = 4'($urandom_range(0, 15));
    tri_mode = ~tri_mode;
    while (done_cnt == 0 && (edges - base) < 300) begin
      if (v.rep_k > 0 && (edges - base) == v.rep_k) begin
        start = 1'b1;
        first_row = 4'd0;
        last_row = 4'd15;
      end else start = 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (done_cnt == 0) fail_now("done_timeout");
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("done_pulses", done_cnt, 1);
    chk("words", words_got, v.exp_n);
    chk("model_n", n, v.exp_n);
    chk("leftover", exp_q.size(), 0);
    chk("reads", rd_cnt, v.exp_n);
    chk("busy_after", busy, 0);
    if (v.exp_done >= 0) chk("done_cycle", done_k, v.exp_done);
    if (v.mode == 0 && v.exp_n > 0) begin
      chk("first_valid", first_valid_k, 3);
      chk("valid_cycles", valid_cnt, v.exp_n);
    end
    if (v.exp_n == 0) chk("no_valid", valid_cnt, 0);
    mon_on = 0;
    ready_mode = 0;
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    start = 1'b0;
    first_row = '0;
    last_row = '0;
    tri_mode = 1'b0;
    rd_data = '0;
    for (int r = 0; r < 16; r++) mem[r] = '0;

    tbl.push_back('{1, 6, 1, 0, 0, 0, 9, 6});
    tbl.push_back('{0, 15, 0, 1, 0, 0, 19, 16});
    tbl.push_back('{2, 5, 0, 1, 2, 0, -1, 4});
    tbl.push_back('{9, 4, 1, 1, 0, 0, 2, 0});
    tbl.push_back('{3, 8, 1, 2, 0, 3, 9, 6});
    tbl.push_back('{4, 5, 1, 1, 0, 5, 5, 2});
    tbl.push_back('{15, 15, 1, 1, 0, 0, 4, 1});
    tbl.push_back('{0, 0, 1, 1, 0, 0, 4, 1});
    tbl.push_back('{7, 12, 1, 2, 1, 0, -1, 6});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // Reset in cycle 4 of a full-range run.
    for (int r = 0; r < 16; r++) mem[r] = 8'(r * 17);
    @(posedge clk);
    #1;
    base = edges;
    start = 1'b1;
    first_row = 4'd0;
    last_row = 4'd15;
    tri_mode = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    while ((edges - base) < 4) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_index", out_index, 0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_done", done, 0);
    end
    run(tbl[1]);

    // Randomized runs.
    for (int i = 0; i < 10; i++) begin
      int n;
      v.first = $urandom_range(0, 15);
      v.last  = $urandom_range(0, 15);
      v.tmode = $urandom_range(0, 1);
      v.pat   = 2;
      v.mode  = $urandom_range(0, 2);
      v.rep_k = 0;
      n = (v.first <= v.last) ? (v.last - v.first + 1) : 0;
      v.exp_n = n;
      v.exp_done = (v.mode == 0) ? ((n > 0) ? n + 3 : 2) : -1;
      run(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
